// File: rtl/dibit_frame_sync.sv
// Dibit-stream frame synchroniser: hunts for the sync word, confirms it with a
// flywheel, packs payload dibits into bytes and queues them in a 2-entry buffer.
module dibit_frame_sync #(
    parameter int                  SYNC_LEN    = 16,
    parameter logic [SYNC_LEN-1:0] SYNC_WORD   = 16'hF628,
    parameter int                  FRAME_BYTES = 4,
    parameter int                  MAX_ERR     = 0,
    parameter int                  VERIFY_CNT  = 2,
    parameter int                  MISS_MAX    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] dibit_in,
    input  logic       dibit_valid,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    input  logic       byte_ready,
    output logic       locked,
    output logic       sync_pulse,
    output logic       overflow
);

    localparam int PAY_DIBITS = FRAME_BYTES * 4;
    localparam int CHK_DIBITS = SYNC_LEN / 2;
    localparam int CNT_W      = 10;
    localparam int HIT_W      = 8;

    typedef enum logic [1:0] {ST_SEARCH, ST_PAYLOAD, ST_CHECK} state_t;

    state_t              state_q, state_d;
    logic [SYNC_LEN-1:0] sr_q, sr_d;
    logic [5:0]          acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [HIT_W-1:0]    hits_q, hits_d;
    logic [HIT_W-1:0]    misses_q, misses_d;
    logic                locked_q, locked_d;
    logic                sync_pulse_q, sync_pulse_d;
    logic                overflow_q, overflow_d;
    logic [7:0]          fifo_q [2];
    logic [7:0]          fifo_d [2];
    logic                rd_ptr_q, rd_ptr_d;
    logic                wr_ptr_q, wr_ptr_d;
    logic [1:0]          count_q, count_d;

    logic [SYNC_LEN-1:0] next_sr;
    logic [7:0]          byte_new;
    logic                sr_match, last_payload, last_check, miss_exit;
    logic [HIT_W-1:0]    hits_inc, misses_inc;
    logic                push, pop, accept;

    function automatic int popcount(input logic [SYNC_LEN-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < SYNC_LEN; i++) n += int'(v[i]);
        return n;
    endfunction

    assign next_sr      = {sr_q[SYNC_LEN-3:0], dibit_in};
    assign byte_new     = {acc_q, dibit_in};
    assign sr_match     = popcount(next_sr ^ SYNC_WORD) <= MAX_ERR;
    assign last_payload = (cnt_q == CNT_W'(PAY_DIBITS - 1));
    assign last_check   = (cnt_q == CNT_W'(CHK_DIBITS - 1));
    assign hits_inc     = (hits_q >= HIT_W'(VERIFY_CNT)) ? hits_q : hits_q + HIT_W'(1);
    assign misses_inc   = misses_q + HIT_W'(1);
    assign miss_exit    = (misses_inc >= HIT_W'(MISS_MAX));

    // State register (all flops, async reset)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_SEARCH;
            sr_q         <= '0;
            acc_q        <= '0;
            cnt_q        <= '0;
            hits_q       <= '0;
            misses_q     <= '0;
            locked_q     <= 1'b0;
            sync_pulse_q <= 1'b0;
            overflow_q   <= 1'b0;
            rd_ptr_q     <= 1'b0;
            wr_ptr_q     <= 1'b0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            sr_q         <= sr_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            hits_q       <= hits_d;
            misses_q     <= misses_d;
            locked_q     <= locked_d;
            sync_pulse_q <= sync_pulse_d;
            overflow_q   <= overflow_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
            always_ff @(posedge clk or posedge rst) begin
                if (rst) fifo_q[gi] <= '0;
                else     fifo_q[gi] <= fifo_d[gi];
            end
        end
    endgenerate

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (dibit_valid) begin
            case (state_q)
                ST_SEARCH:  if (sr_match) state_d = ST_PAYLOAD;
                ST_PAYLOAD: if (last_payload) state_d = ST_CHECK;
                ST_CHECK: begin
                    if (last_check) begin
                        if (sr_match)                 state_d = ST_PAYLOAD;
                        else if (!locked_q || miss_exit) state_d = ST_SEARCH;
                        else                          state_d = ST_PAYLOAD;
                    end
                end
                default:    state_d = ST_SEARCH;
            endcase
        end
    end

    // Counters, lock tracking and byte assembly
    always_comb begin
        sr_d         = sr_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        hits_d       = hits_q;
        misses_d     = misses_q;
        locked_d     = locked_q;
        sync_pulse_d = 1'b0;
        push         = 1'b0;
        if (dibit_valid) begin
            sr_d  = next_sr;
            acc_d = byte_new[5:0];
            case (state_q)
                ST_SEARCH: begin
                    if (sr_match) begin
                        sync_pulse_d = 1'b1;
                        cnt_d        = '0;
                        hits_d       = HIT_W'(1);
                        misses_d     = '0;
                        locked_d     = (VERIFY_CNT == 1);
                    end
                end
                ST_PAYLOAD: begin
                    push  = locked_q && (cnt_q[1:0] == 2'd3);
                    cnt_d = last_payload ? '0 : cnt_q + CNT_W'(1);
                end
                ST_CHECK: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (last_check) begin
                        cnt_d = '0;
                        if (sr_match) begin
                            sync_pulse_d = 1'b1;
                            misses_d     = '0;
                            hits_d       = hits_inc;
                            if (hits_inc >= HIT_W'(VERIFY_CNT)) locked_d = 1'b1;
                        end else if (!locked_q) begin
                            hits_d = '0;
                        end else begin
                            // Flywheel: tolerate a few bad syncs before dropping lock
                            misses_d = misses_inc;
                            if (miss_exit) begin
                                locked_d = 1'b0;
                                hits_d   = '0;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Output buffer: a pop frees a slot for a same-cycle push
    always_comb begin
        fifo_d     = fifo_q;
        pop        = (count_q != 2'd0) && byte_ready;
        accept     = push && ((count_q != 2'd2) || pop);
        overflow_d = overflow_q | (push & ~accept);
        if (accept) fifo_d[wr_ptr_q] = byte_new;
        wr_ptr_d   = wr_ptr_q ^ accept;
        rd_ptr_d   = rd_ptr_q ^ pop;
        count_d    = count_q + {1'b0, accept} - {1'b0, pop};
    end

    assign byte_out   = fifo_q[rd_ptr_q];
    assign byte_valid = (count_q != 2'd0);
    assign locked     = locked_q;
    assign sync_pulse = sync_pulse_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_dibit_frame_sync.sv
// Self-checking bench for dibit_frame_sync: directed scenarios plus randomized
// frames, all compared against a frame-position reference model.
module tb_dibit_frame_sync;

    localparam logic [15:0] SYNC = 16'hF628;
    localparam int PAY = 16;
    localparam int CHK = 8;
    localparam int VC  = 2;
    localparam int MM  = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] dibit_in = 2'd0;
    logic       dibit_valid = 1'b0;
    logic       byte_ready = 1'b0;
    logic [7:0] byte_out;
    logic       byte_valid, locked, sync_pulse, overflow;

    logic       rst_e = 1'b1;
    logic [1:0] e_dibit = 2'd0;
    logic       e_valid = 1'b0;
    logic       e_ready = 1'b1;
    logic [7:0] e_byte_out;
    logic       e_byte_valid, e_locked, e_pulse, e_overflow;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dibit_frame_sync dut (
        .clk(clk), .rst(rst), .dibit_in(dibit_in), .dibit_valid(dibit_valid),
        .byte_out(byte_out), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .locked(locked), .sync_pulse(sync_pulse), .overflow(overflow)
    );

    dibit_frame_sync #(.MAX_ERR(1)) dut_e1 (
        .clk(clk), .rst(rst_e), .dibit_in(e_dibit), .dibit_valid(e_valid),
        .byte_out(e_byte_out), .byte_valid(e_byte_valid), .byte_ready(e_ready),
        .locked(e_locked), .sync_pulse(e_pulse), .overflow(e_overflow)
    );

    // Reference model: position within the current frame, FIFO as a queue
    int         m_sr, m_acc, m_pos, m_hits, m_misses;
    bit         m_in_frame, m_locked, m_pulse, m_ovf;
    logic [7:0] m_q[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_sr = 0; m_acc = 0; m_pos = 0; m_hits = 0; m_misses = 0;
        m_in_frame = 0; m_locked = 0; m_pulse = 0; m_ovf = 0;
        m_q.delete();
    endtask

    task automatic model_edge(input bit v, input logic [1:0] d, input bit r);
        bit pop, push, match;
        logic [7:0] pb;
        pop  = (m_q.size() > 0) && r;
        push = 0;
        pb   = 8'h00;
        m_pulse = 0;
        if (v) begin
            m_sr  = ((m_sr << 2) | int'(d)) & 32'hFFFF;
            m_acc = ((m_acc << 2) | int'(d)) & 32'hFF;
            match = ($countones(m_sr ^ int'(SYNC)) == 0);
            if (!m_in_frame) begin
                if (match) begin
                    m_pulse = 1; m_in_frame = 1; m_pos = 0;
                    m_hits = 1; m_misses = 0; m_locked = (VC == 1);
                end
            end else if (m_pos < PAY) begin
                if ((m_pos % 4) == 3 && m_locked) begin
                    push = 1;
                    pb   = m_acc[7:0];
                end
                m_pos++;
            end else if (m_pos == PAY + CHK - 1) begin
                m_pos = 0;
                if (match) begin
                    m_pulse = 1; m_misses = 0;
                    m_hits = (m_hits + 1 > VC) ? VC : m_hits + 1;
                    if (m_hits >= VC) m_locked = 1;
                end else if (!m_locked) begin
                    m_in_frame = 0; m_hits = 0;
                end else begin
                    m_misses++;
                    if (m_misses >= MM) begin
                        m_locked = 0; m_in_frame = 0; m_hits = 0;
                    end
                end
            end else begin
                m_pos++;
            end
        end
        if (pop) begin
            $display("byte %02h delivered at %0t", m_q[0], $time);
            void'(m_q.pop_front());
        end
        if (push) begin
            if (m_q.size() == 2) m_ovf = 1;
            else m_q.push_back(pb);
        end
    endtask

    task automatic compare_all();
        check_val("byte_valid", byte_valid, (m_q.size() != 0));
        if (m_q.size() != 0) check_val("byte_out", byte_out, m_q[0]);
        check_val("locked", locked, m_locked);
        check_val("sync_pulse", sync_pulse, m_pulse);
        check_val("overflow", overflow, m_ovf);
    endtask

    task automatic step(input bit v, input logic [1:0] d, input bit r);
        dibit_valid = v;
        dibit_in    = d;
        byte_ready  = r;
        @(posedge clk);
        model_edge(v, d, r);
        #1;
        compare_all();
    endtask

    task automatic send_word(input logic [15:0] w, input bit r);
        for (int i = 7; i >= 0; i--) step(1'b1, w[2*i +: 2], r);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit r);
        for (int i = 3; i >= 0; i--) step(1'b1, b[2*i +: 2], r);
    endtask

    task automatic e_word(input logic [15:0] w, input logic exp, input string tag);
        for (int i = 7; i >= 0; i--) begin
            e_valid = 1'b1;
            e_dibit = w[2*i +: 2];
            step(1'b0, 2'd0, 1'b1);
        end
        check_val(tag, e_pulse, exp);
        e_valid = 1'b0;
        step(1'b0, 2'd0, 1'b1);
        check_val({tag, "_after"}, e_pulse, 1'b0);
    endtask

    initial begin
        logic [7:0]  pat [4];
        logic [15:0] w;
        model_reset();
        #1;
        compare_all();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        rst_e = 1'b0;

        // 1: sync alone gives one pulse, no lock
        send_word(SYNC, 1'b1);
        check_val("t1_pulse", sync_pulse, 1'b1);
        check_val("t1_locked", locked, 1'b0);

        // 2: second sync locks, payload emerges in order
        for (int i = 0; i < 4; i++) send_byte(8'h00, 1'b1);
        send_word(SYNC, 1'b1);
        check_val("t2_locked", locked, 1'b1);
        pat = '{8'hAA, 8'h55, 8'h01, 8'hFE};
        for (int i = 0; i < 4; i++) begin
            send_byte(pat[i], 1'b1);
            check_val("t2_byte", byte_out, pat[i]);
        end

        // 3: stalled consumer, third and fourth bytes dropped
        send_word(SYNC, 1'b1);
        pat = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) send_byte(pat[i], 1'b0);
        check_val("t3_overflow", overflow, 1'b1);
        check_val("t3_head", byte_out, 8'h11);
        step(1'b0, 2'd0, 1'b1);
        check_val("t3_second", byte_out, 8'h22);
        step(1'b0, 2'd0, 1'b1);
        check_val("t3_empty", byte_valid, 1'b0);

        // 4: two bad syncs drop lock, clean sync re-acquires
        send_word(16'hF62F, 1'b1);
        check_val("t4_flywheel", locked, 1'b1);
        for (int i = 0; i < 4; i++) send_byte(8'(i * 37 + 5), 1'b1);
        send_word(16'h8628, 1'b1);
        check_val("t4_unlock", locked, 1'b0);
        send_word(SYNC, 1'b1);
        check_val("t4_resync", sync_pulse, 1'b1);

        // 6: async reset mid-byte with a byte buffered
        for (int i = 0; i < 4; i++) send_byte(8'h00, 1'b1);
        send_word(SYNC, 1'b1);
        send_byte(8'h5A, 1'b0);
        step(1'b1, 2'd1, 1'b0);
        step(1'b1, 2'd2, 1'b0);
        check_val("t6_pre_valid", byte_valid, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check_val("t6_valid", byte_valid, 1'b0);
        check_val("t6_locked", locked, 1'b0);
        check_val("t6_overflow", overflow, 1'b0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 12; i++) step(1'b1, 2'd0, 1'b1);
        check_val("t6_no_stale", byte_valid, 1'b0);

        // 5: tolerant instance accepts one bit error, rejects two
        rst_e = 1'b1;
        step(1'b0, 2'd0, 1'b1);
        rst_e = 1'b0;
        e_word(16'hF629, 1'b1, "t5_one_err");
        rst_e = 1'b1;
        step(1'b0, 2'd0, 1'b1);
        rst_e = 1'b0;
        e_word(16'hF62B, 1'b0, "t5_two_err");

        // Randomized frames with idle gaps, junk and corrupted syncs
        for (int f = 0; f < 40; f++) begin
            if ((f % 7) == 3) begin
                for (int j = 0; j < 1 + int'($urandom_range(4)); j++)
                    step(1'b1, 2'($urandom), ($urandom % 3) != 0);
            end
            w = SYNC;
            if (($urandom % 5) == 0) begin
                for (int j = 0; j < 1 + int'($urandom_range(2)); j++)
                    w[$urandom_range(15)] ^= 1'b1;
            end
            for (int i = 7; i >= 0; i--) begin
                if (($urandom % 4) == 0) step(1'b0, 2'd0, ($urandom % 3) != 0);
                step(1'b1, w[2*i +: 2], ($urandom % 3) != 0);
            end
            for (int i = 0; i < PAY; i++) begin
                if (($urandom % 4) == 0) step(1'b0, 2'd0, ($urandom % 3) != 0);
                step(1'b1, 2'($urandom), ($urandom % 3) != 0);
            end
        end
        for (int i = 0; i < 4; i++) step(1'b0, 2'd0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
